ifu_fetch: RTL and testbench

Instruction fetch unit for the multicycle core; sits directly downstream of the next-PC register. On each new PC it issues one read request on a simple address/data handshake bus, captures the returned instruction and presents it with its PC to the decode stage via a valid/ready handshake. It is a multicycle FSM with at most one fetch in flight. Fetch count and error status are exported for the simulation environment.

---
 rtl/ifu_fetch.sv | 140 ++++++++++++++
 tb/tb_ifu_fetch.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch FSM: one read in flight, result held for decode; 3 cycles pc_valid->inst_valid with zero-wait memory.
// Backpressure: arready/rvalid waits stretch AR/R; inst_ready low holds OUT and blocks new PCs.
module ifu_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_valid,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_ready,
  output logic              arvalid,
  output logic [ADDR_W-1:0] araddr,
  input  logic              arready,
  input  logic              rvalid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  output logic              rready,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  output logic              fetch_err,
  output logic [31:0]       fetch_cnt
);

  typedef enum logic [2:0] {
    S_BOOT = 3'd0,
    S_IDLE = 3'd1,
    S_AR   = 3'd2,
    S_R    = 3'd3,
    S_OUT  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              fetch_err_q, fetch_err_d;
  logic [31:0]       fetch_cnt_q, fetch_cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_BOOT;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_BOOT: state_d = S_AR;
      S_IDLE: if (pc_valid) state_d = (pc_in[1:0] == 2'b00) ? S_AR : S_OUT;
      S_AR:   if (arready) state_d = S_R;
      S_R:    if (rvalid) state_d = S_OUT;
      S_OUT:  if (inst_ready) state_d = S_IDLE;
      default: state_d = S_BOOT;
    endcase
  end

  // Handshake outputs depend only on the state register, never on inputs.
  always_comb begin
    pc_ready   = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    inst_valid = 1'b0;
    unique case (state_q)
      S_IDLE:  pc_ready   = 1'b1;
      S_AR:    arvalid    = 1'b1;
      S_R:     rready     = 1'b1;
      S_OUT:   inst_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    araddr_d    = araddr_q;
    inst_d      = inst_q;
    inst_pc_d   = inst_pc_q;
    fetch_err_d = fetch_err_q;
    fetch_cnt_d = fetch_cnt_q;
    unique case (state_q)
      S_BOOT: begin
        araddr_d  = RESET_PC;
        inst_pc_d = RESET_PC;
      end
      S_IDLE: begin
        if (pc_valid) begin
          araddr_d  = pc_in;
          inst_pc_d = pc_in;
          // Misaligned PC skips the bus and is reported as a faulting fetch.
          if (pc_in[1:0] != 2'b00) begin
            inst_d      = '0;
            fetch_err_d = 1'b1;
          end
        end
      end
      S_R: begin
        if (rvalid) begin
          inst_d      = rdata;
          fetch_err_d = (rresp != 2'b00);
        end
      end
      S_OUT: begin
        if (inst_ready) fetch_cnt_d = fetch_cnt_q + 32'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      araddr_q    <= RESET_PC;
      inst_q      <= '0;
      inst_pc_q   <= '0;
      fetch_err_q <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      araddr_q    <= araddr_d;
      inst_q      <= inst_d;
      inst_pc_q   <= inst_pc_d;
      fetch_err_q <= fetch_err_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign araddr    = araddr_q;
  assign inst      = inst_q;
  assign inst_pc   = inst_pc_q;
  assign fetch_err = fetch_err_q;
  assign fetch_cnt = fetch_cnt_q;

  a_onehot_hs: assert property (@(posedge clk) disable iff (!rst)
    $onehot0({pc_ready, arvalid, rready, inst_valid}));
  a_ar_stable: assert property (@(posedge clk) disable iff (!rst)
    (arvalid && !arready) |=> (arvalid && $stable(araddr)));
  a_out_stable: assert property (@(posedge clk) disable iff (!rst)
    (inst_valid && !inst_ready) |=>
      (inst_valid && $stable(inst) && $stable(inst_pc) && $stable(fetch_err)));

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pc_valid = 1'b0;
  logic [31:0] pc_in = '0;
  logic        pc_ready;
  logic        arvalid;
  logic [31:0] araddr;
  logic        arready = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        fetch_err;
  logic [31:0] fetch_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_cnt = 0;

  ifu_fetch #(.ADDR_W(32), .DATA_W(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .pc_valid(pc_valid), .pc_in(pc_in), .pc_ready(pc_ready),
    .arvalid(arvalid), .araddr(araddr), .arready(arready), .rvalid(rvalid),
    .rdata(rdata), .rresp(rresp), .rready(rready), .inst_valid(inst_valid),
    .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready), .fetch_err(fetch_err),
    .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory side of one fetch. Returns cycles from the pc_valid edge to inst_valid,
  // the cycle arvalid was first seen, the requested address and whether it moved.
  task automatic fetch(input bit boot, input logic [31:0] pc, input int aw, input int rw,
                       input logic [1:0] resp, input logic [31:0] data,
                       output int lat, output int ar_at, output bit saw_ar,
                       output logic [31:0] ar_addr, output bit ar_moved);
    int ac = 0;
    int rc = 0;
    saw_ar = 1'b0; ar_addr = '0; ar_moved = 1'b0; ar_at = 0;
    if (!boot) begin
      pc_valid = 1'b1;
      pc_in    = pc;
    end
    step();
    pc_valid = 1'b0;
    pc_in    = $urandom;
    lat      = 1;
    for (int i = 0; i < 200 && !inst_valid; i++) begin
      arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = $urandom;
      if (arvalid) begin
        if (!saw_ar) begin
          ar_addr = araddr;
          ar_at   = lat;
        end else if (araddr !== ar_addr) ar_moved = 1'b1;
        saw_ar  = 1'b1;
        arready = (ac >= aw);
        ac++;
        rvalid  = 1'($urandom_range(0, 1));
      end else if (rready) begin
        rvalid = (rc >= rw);
        rc++;
        if (rvalid) begin
          rdata = data;
          rresp = resp;
        end
      end
      step();
      lat++;
    end
    arready = 1'b0; rvalid = 1'b0; rresp = 2'b00;
  endtask

  task automatic accept();
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
  endtask

  task automatic test_reset();
    int lat, ar_at; bit saw; bit moved; logic [31:0] a;
    logic [132:0] got, want;
    rst = 1'b0;
    repeat (2) step();
    got  = {pc_ready, arvalid, araddr, rready, inst_valid, inst, inst_pc, fetch_err, fetch_cnt};
    want = {1'b0, 1'b0, RST_PC, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0};
    n_chk++; if (got !== want) $display("FAIL reset_values got %h want %h", got, want); else n_pass++;
    rst = 1'b1;
    exp_cnt = 0;
    n_chk++; if ({pc_ready, arvalid, rready, inst_valid} !== 4'b0000)
      $display("FAIL boot_outputs got %b want 0000", {pc_ready, arvalid, rready, inst_valid}); else n_pass++;
    fetch(1'b1, 32'h0, 0, 0, 2'b00, 32'h0000_0413, lat, ar_at, saw, a, moved);
    n_chk++; if (ar_at !== 1 || a !== RST_PC)
      $display("FAIL boot_ar got at=%0d addr=%h want at=1 addr=%h", ar_at, a, RST_PC); else n_pass++;
    n_chk++; if (lat !== 3) $display("FAIL boot_latency got %0d want 3", lat); else n_pass++;
    n_chk++; if ({inst, inst_pc, fetch_err} !== {32'h0000_0413, RST_PC, 1'b0})
      $display("FAIL boot_inst got %h/%h/%b want 00000413/%h/0", inst, inst_pc, fetch_err, RST_PC); else n_pass++;
    accept(); exp_cnt++;
    n_chk++; if (fetch_cnt !== 32'(exp_cnt) || pc_ready !== 1'b1)
      $display("FAIL boot_cnt got cnt=%0d rdy=%b want cnt=%0d rdy=1", fetch_cnt, pc_ready, exp_cnt); else n_pass++;
  endtask

  task automatic test_latency();
    int lat, ar_at; bit saw; bit moved; logic [31:0] a;
    fetch(1'b0, 32'h8000_0004, 0, 0, 2'b00, 32'h1111_2222, lat, ar_at, saw, a, moved);
    n_chk++; if (lat !== 3 || ar_at !== 1 || a !== 32'h8000_0004)
      $display("FAIL lat_zero_wait got lat=%0d ar_at=%0d addr=%h want 3/1/80000004", lat, ar_at, a); else n_pass++;
    accept(); exp_cnt++;
    fetch(1'b0, 32'h8000_0008, 2, 3, 2'b00, 32'h3333_4444, lat, ar_at, saw, a, moved);
    n_chk++; if (lat !== 8 || moved !== 1'b0 || inst !== 32'h3333_4444)
      $display("FAIL lat_waits got lat=%0d moved=%b inst=%h want 8/0/33334444", lat, moved, inst); else n_pass++;
    accept(); exp_cnt++;
  endtask

  task automatic test_misaligned();
    int lat, ar_at; bit saw; bit moved; logic [31:0] a;
    fetch(1'b0, 32'h8000_0006, 0, 0, 2'b00, 32'h5555_5555, lat, ar_at, saw, a, moved);
    n_chk++; if (lat !== 1 || saw !== 1'b0)
      $display("FAIL misaligned_timing got lat=%0d saw_ar=%b want 1/0", lat, saw); else n_pass++;
    n_chk++; if ({inst, inst_pc, fetch_err} !== {32'h0, 32'h8000_0006, 1'b1})
      $display("FAIL misaligned_inst got %h/%h/%b want 00000000/80000006/1", inst, inst_pc, fetch_err); else n_pass++;
    accept(); exp_cnt++;
    n_chk++; if (fetch_cnt !== 32'(exp_cnt))
      $display("FAIL misaligned_cnt got %0d want %0d", fetch_cnt, exp_cnt); else n_pass++;
  endtask

  task automatic test_bus_error();
    int lat, ar_at; bit saw; bit moved; logic [31:0] a;
    fetch(1'b0, 32'h8000_0100, 1, 0, 2'd2, 32'hdead_beef, lat, ar_at, saw, a, moved);
    n_chk++; if ({inst, fetch_err} !== {32'hdead_beef, 1'b1})
      $display("FAIL bus_error got %h/%b want deadbeef/1", inst, fetch_err); else n_pass++;
    accept(); exp_cnt++;
    fetch(1'b0, 32'h8000_0104, 0, 1, 2'd0, 32'h0000_0013, lat, ar_at, saw, a, moved);
    n_chk++; if ({inst, fetch_err} !== {32'h0000_0013, 1'b0})
      $display("FAIL bus_error_clear got %h/%b want 00000013/0", inst, fetch_err); else n_pass++;
    accept(); exp_cnt++;
  endtask

  task automatic test_stall();
    int lat, ar_at; bit saw; bit moved; logic [31:0] a;
    logic [101:0] got, want;
    fetch(1'b0, 32'h8000_0200, 0, 0, 2'b00, 32'hcafe_f00d, lat, ar_at, saw, a, moved);
    want = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hcafe_f00d, 32'h8000_0200, 32'(exp_cnt)};
    for (int i = 0; i < 10; i++) begin
      pc_valid = 1'($urandom_range(0, 1));
      pc_in    = $urandom;
      rvalid   = 1'($urandom_range(0, 1));
      rdata    = $urandom;
      rresp    = 2'($urandom_range(0, 3));
      step();
      got = {inst_valid, pc_ready, arvalid, rready, fetch_err, inst, inst_pc, fetch_cnt};
      n_chk++; if (got !== want) $display("FAIL stall_hold cycle %0d got %h want %h", i, got, want); else n_pass++;
    end
    pc_valid = 1'b0; rvalid = 1'b0; rresp = 2'b00;
    accept(); exp_cnt++;
    n_chk++; if (fetch_cnt !== 32'(exp_cnt)) $display("FAIL stall_cnt got %0d want %0d", fetch_cnt, exp_cnt); else n_pass++;
    step();
    n_chk++; if (fetch_cnt !== 32'(exp_cnt) || pc_ready !== 1'b1)
      $display("FAIL stall_once got cnt=%0d rdy=%b want cnt=%0d rdy=1", fetch_cnt, pc_ready, exp_cnt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat, ar_at; bit saw; bit moved; logic [31:0] a;
    fetch(1'b0, 32'h8000_0300, 0, 0, 2'b00, 32'h0101_0101, lat, ar_at, saw, a, moved);
    accept(); exp_cnt++;
    n_chk++; if ({pc_ready, arvalid} !== 2'b10)
      $display("FAIL b2b_ready got pc_ready=%b arvalid=%b want 1/0", pc_ready, arvalid); else n_pass++;
    pc_valid = 1'b1; pc_in = 32'h8000_0304;
    step();
    pc_valid = 1'b0;
    n_chk++; if ({arvalid, araddr} !== {1'b1, 32'h8000_0304})
      $display("FAIL b2b_ar got %b/%h want 1/80000304", arvalid, araddr); else n_pass++;
    arready = 1'b1; step(); arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h0202_0202; step(); rvalid = 1'b0;
    n_chk++; if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h0202_0202, 32'h8000_0304})
      $display("FAIL b2b_inst got %b/%h/%h want 1/02020202/80000304", inst_valid, inst, inst_pc); else n_pass++;
    accept(); exp_cnt++;
  endtask

  task automatic test_reset_in_r();
    logic [132:0] got, want;
    pc_valid = 1'b1; pc_in = 32'h8000_0010; step(); pc_valid = 1'b0;
    arready = 1'b1; step(); arready = 1'b0;
    n_chk++; if (rready !== 1'b1) $display("FAIL rst_r_setup got rready=%b want 1", rready); else n_pass++;
    rst = 1'b0;
    #1;
    got  = {pc_ready, arvalid, araddr, rready, inst_valid, inst, inst_pc, fetch_err, fetch_cnt};
    want = {1'b0, 1'b0, RST_PC, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0};
    n_chk++; if (got !== want) $display("FAIL rst_async got %h want %h", got, want); else n_pass++;
    exp_cnt = 0;
    step();
    rst = 1'b1;
    rvalid = 1'b1; rdata = 32'hbad0_bad0;
    step();
    n_chk++; if ({arvalid, rready, araddr} !== {1'b1, 1'b0, RST_PC})
      $display("FAIL rst_refetch got %b/%b/%h want 1/0/%h", arvalid, rready, araddr, RST_PC); else n_pass++;
    step();
    rvalid = 1'b0; arready = 1'b1; step(); arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h0000_0517; step(); rvalid = 1'b0;
    n_chk++; if ({inst_valid, inst, inst_pc, fetch_cnt} !== {1'b1, 32'h0000_0517, RST_PC, 32'h0})
      $display("FAIL rst_no_stale got %b/%h/%h/%0d want 1/00000517/%h/0", inst_valid, inst, inst_pc, fetch_cnt, RST_PC); else n_pass++;
    accept(); exp_cnt++;
    n_chk++; if (fetch_cnt !== 32'(exp_cnt)) $display("FAIL rst_cnt_restart got %0d want %0d", fetch_cnt, exp_cnt); else n_pass++;
  endtask

  task automatic test_random();
    int lat, ar_at; bit saw; bit moved; logic [31:0] a;
    logic [31:0] pc, data; logic [1:0] resp; bit mis; int aw, rw;
    logic [105:0] got, want;
    for (int n = 0; n < 40; n++) begin
      mis  = ($urandom_range(0, 3) == 0);
      pc   = $urandom;
      if (!mis) pc[1:0] = 2'b00;
      else if (pc[1:0] == 2'b00) pc[1:0] = 2'b01;
      aw   = $urandom_range(0, 3);
      rw   = $urandom_range(0, 3);
      resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      data = $urandom;
      fetch(1'b0, pc, aw, rw, resp, data, lat, ar_at, saw, a, moved);
      got  = {8'(lat), saw, moved, a, inst, inst_pc, fetch_err};
      want = {mis ? 8'd1 : 8'(3 + aw + rw), !mis, 1'b0, mis ? 32'h0 : pc,
              mis ? 32'h0 : data, pc, mis || (resp != 2'b00)};
      n_chk++; if (got !== want) $display("FAIL random_fetch %0d got %h want %h", n, got, want); else n_pass++;
      repeat ($urandom_range(0, 2)) step();
      accept(); exp_cnt++;
      n_chk++; if (fetch_cnt !== 32'(exp_cnt) || pc_ready !== 1'b1)
        $display("FAIL random_cnt %0d got cnt=%0d rdy=%b want cnt=%0d rdy=1", n, fetch_cnt, pc_ready, exp_cnt); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_misaligned();
    test_bus_error();
    test_stall();
    test_back_to_back();
    test_reset_in_r();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
